spi_pollable_memory_burst: RTL

- Parametrised successor to the fixed command8/address16/data32 SPI-pollable RAM.
- An SPI mode-0 slave, oversampled in the system clock domain, fronts an inferred dual-port memory of configurable width and depth.
- Adds auto-increment burst read/write, read-back of old contents during writes, error/word counters and a local fabric read port.
- Sits between the Raspberry Pi SPI pins and fabric logic that polls or consumes the stored words.

---
 rtl/spi_pollable_memory_burst.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_pollable_memory_burst.sv
// SPI mode-0 slave, oversampled in the system clock domain, in front of a
// dual-port word memory. Supports single/burst read and write with
// auto-increment, old-data read-back during writes, commit/error counters
// and a registered fabric read port.
module spi_pollable_memory_burst #(
   parameter int unsigned ADDRESS_WIDTH = 9,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned COUNTER_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     SCK,
   input  logic                     MOSI,
   output logic                     MISO,
   input  logic                     SSEL,
   output logic                     transaction_valid,
   output logic [ADDRESS_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0]    data,
   output logic [COUNTER_WIDTH-1:0] word_count,
   output logic [COUNTER_WIDTH-1:0] error_count,
   input  logic [ADDRESS_WIDTH-1:0] local_read_address,
   output logic [DATA_WIDTH-1:0]    local_read_data
);

   localparam int unsigned DEPTH     = 2 ** ADDRESS_WIDTH;
   localparam int unsigned FIELD_MAX = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
   localparam int unsigned BIT_W     = $clog2(FIELD_MAX);

   localparam logic [7:0] CMD_NOP       = 8'h00;
   localparam logic [7:0] CMD_WR_SINGLE = 8'h01;
   localparam logic [7:0] CMD_RD_SINGLE = 8'h02;
   localparam logic [7:0] CMD_WR_BURST  = 8'h03;
   localparam logic [7:0] CMD_RD_BURST  = 8'h04;

   localparam logic [BIT_W-1:0] LAST_CMD_BIT  = BIT_W'(7);
   localparam logic [BIT_W-1:0] LAST_ADDR_BIT = BIT_W'(15);
   localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COMMAND,
      ST_ADDRESS,
      ST_DATA,
      ST_SKIP
   } state_t;

   state_t state, next_state;

   logic [2:0]               sck_sync, mosi_sync, ssel_sync;
   logic                     sck_rise, sck_fall, ssel_fall, ssel_high, mosi_bit;
   logic [BIT_W-1:0]         bit_cnt;
   logic [14:0]              hdr_shift;
   logic [DATA_WIDTH-2:0]    shift_in;
   logic [DATA_WIDTH-1:0]    shift_out;
   logic [DATA_WIDTH-1:0]    spi_rdata;
   logic [7:0]               cmd;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic                     prefetch_req, prefetch_load;
   logic                     wr_pending;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     miso_q;

   logic [7:0]               cmd_byte;
   logic [DATA_WIDTH-1:0]    data_word;
   logic                     cmd_known, cmd_error, is_write, is_burst, mem_we;
   logic                     cmd_done, addr_done, word_done;

   logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

   // Two-flop synchronisers plus a history flop for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         ssel_sync <= '0;
      end else begin
         sck_sync  <= {sck_sync[1:0], SCK};
         mosi_sync <= {mosi_sync[1:0], MOSI};
         ssel_sync <= {ssel_sync[1:0], SSEL};
      end
   end

   assign sck_rise  = sck_sync[1] & ~sck_sync[2];
   assign sck_fall  = ~sck_sync[1] & sck_sync[2];
   assign ssel_fall = ~ssel_sync[1] & ssel_sync[2];
   assign ssel_high = ssel_sync[1];
   // MOSI taken from the history flop so it is at least as old as the SCK edge.
   assign mosi_bit  = mosi_sync[2];

   assign cmd_byte  = {hdr_shift[6:0], mosi_bit};
   assign data_word = {shift_in, mosi_bit};
   assign cmd_known = (cmd_byte == CMD_WR_SINGLE) || (cmd_byte == CMD_RD_SINGLE) ||
                      (cmd_byte == CMD_WR_BURST)  || (cmd_byte == CMD_RD_BURST);
   assign cmd_error = !cmd_known && (cmd_byte != CMD_NOP);
   assign is_write  = (cmd == CMD_WR_SINGLE) || (cmd == CMD_WR_BURST);
   assign is_burst  = (cmd == CMD_WR_BURST)  || (cmd == CMD_RD_BURST);
   assign mem_we    = word_done && is_write && !reset;

   // Frame state register.
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state decode and end-of-field strobes.
   always_comb begin
      next_state = state;
      cmd_done   = 1'b0;
      addr_done  = 1'b0;
      word_done  = 1'b0;
      if (ssel_high) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ssel_fall) next_state = ST_COMMAND;
            end
            ST_COMMAND: begin
               if (sck_rise && bit_cnt == LAST_CMD_BIT) begin
                  cmd_done   = 1'b1;
                  next_state = cmd_known ? ST_ADDRESS : ST_SKIP;
               end
            end
            ST_ADDRESS: begin
               if (sck_rise && bit_cnt == LAST_ADDR_BIT) begin
                  addr_done  = 1'b1;
                  next_state = ST_DATA;
               end
            end
            ST_DATA: begin
               if (sck_rise && bit_cnt == LAST_DATA_BIT) word_done = 1'b1;
            end
            ST_SKIP: next_state = ST_SKIP;
            default: next_state = ST_IDLE;
         endcase
      end
   end

   // Shift registers, address pointer, prefetch pipeline, commit and counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt           <= '0;
         hdr_shift         <= '0;
         shift_in          <= '0;
         shift_out         <= '0;
         cmd               <= '0;
         addr              <= '0;
         prefetch_req      <= 1'b0;
         prefetch_load     <= 1'b0;
         wr_pending        <= 1'b0;
         wr_addr           <= '0;
         wr_data           <= '0;
         miso_q            <= 1'b0;
         transaction_valid <= 1'b0;
         address           <= '0;
         data              <= '0;
         word_count        <= '0;
         error_count       <= '0;
      end else begin
         transaction_valid <= 1'b0;
         wr_pending        <= 1'b0;
         prefetch_req      <= 1'b0;
         prefetch_load     <= prefetch_req;

         if (sck_rise) begin
            hdr_shift <= {hdr_shift[13:0], mosi_bit};
            shift_in  <= data_word[DATA_WIDTH-2:0];
         end

         if (state == ST_IDLE)
            bit_cnt <= '0;
         else if (sck_rise)
            bit_cnt <= (cmd_done || addr_done || word_done) ? '0 : bit_cnt + 1'b1;

         if (cmd_done) begin
            cmd <= cmd_byte;
            if (cmd_error && error_count != '1) error_count <= error_count + 1'b1;
         end

         if (addr_done) begin
            addr         <= ADDRESS_WIDTH'({hdr_shift, mosi_bit});
            prefetch_req <= 1'b1;
         end

         // The memory write uses the pre-increment address; the prefetch
         // request then reads the (possibly incremented) address one clock later.
         if (word_done) begin
            prefetch_req <= 1'b1;
            if (is_burst) addr <= addr + 1'b1;
            if (is_write) begin
               wr_pending <= 1'b1;
               wr_addr    <= addr;
               wr_data    <= data_word;
            end
         end

         if (wr_pending) begin
            transaction_valid <= 1'b1;
            address           <= wr_addr;
            data              <= wr_data;
            word_count        <= word_count + 1'b1;
         end

         if (prefetch_load)
            shift_out <= spi_rdata;
         else if (sck_fall && state == ST_DATA)
            shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};

         if (state != ST_DATA)
            miso_q <= 1'b0;
         else if (sck_fall)
            miso_q <= shift_out[DATA_WIDTH-1];
      end
   end

   assign MISO = miso_q;

   // SPI port: write on word commit, read-before-write for prefetch.
   always_ff @(posedge clock) begin
      if (mem_we) mem[addr] <= data_word;
      spi_rdata <= mem[addr];
   end

   // Fabric read port, one clock of latency.
   always_ff @(posedge clock) begin
      if (reset) local_read_data <= '0;
      else       local_read_data <= mem[local_read_address];
   end

endmodule
